// File: rtl/piso_tx_pkg.sv
// Purpose : shared types and sizing helpers for the piso_tx serial transmitter.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
package piso_tx_pkg;

  // Transmitter FSM: waiting for a word, or shifting one out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  // Width of a counter that must hold 0..n-1.
  // The result is never below 1 bit, so n=1 and n=2 still get a real register.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_tx_bit_timer.sv
// Purpose : modulo-CLKS_PER_BIT tick counter that paces one serial bit period.
// Latency : tick is decoded from the registered count (no input-to-output path).
// Backpressure : none; it counts whenever en=1 and holds at 0 while clr=1.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, clears the count
//   en   - advance the count this cycle
//   clr  - force the count back to 0 (takes priority over en)
//   tick - high while the count sits at its terminal value CLKS_PER_BIT-1
module bit_timer
  import piso_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int TW = cnt_w(CLKS_PER_BIT);
  localparam logic [TW-1:0] TERM = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] tick_cnt_q;
  logic [TW-1:0] tick_cnt_d;

  // With CLKS_PER_BIT=1 the count is pinned at 0 == TERM, so tick is always high.
  assign tick = (tick_cnt_q == TERM);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clr) begin
      tick_cnt_d = '0;
    end else if (en) begin
      // Wrap on the terminal value so the count never passes CLKS_PER_BIT-1.
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Purpose : parallel-in/serial-out transmitter; one WIDTH-bit word per frame, one strobe per bit.
// Latency : first bit on ser_o the cycle after the handshake; done_o on the WIDTH-th strobe.
// Backpressure : ready_o is high only in IDLE; valid_i while a frame is in progress is ignored.
//
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   data_i    - word to send, captured only on valid_i && ready_o
//   valid_i   - data_i is valid
//   ready_o   - transmitter idle and able to accept a word
//   abort_i   - abandon the current frame (no effect while idle)
//   ser_o     - serial data, IDLE_LEVEL when not transmitting
//   strb_o    - one-cycle pulse telling the receiver to shift ser_o in
//   busy_o    - frame in progress
//   done_o    - one-cycle pulse coinciding with the final bit's strobe
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int   WIDTH        = 8,
  parameter int   CLKS_PER_BIT = 4,
  parameter int   MSB_FIRST    = 1,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             abort_i,
  output logic             ser_o,
  output logic             strb_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BW = cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  tx_state_t        state_q;
  tx_state_t        state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [BW-1:0]    bit_cnt_q;
  logic [BW-1:0]    bit_cnt_d;

  logic in_shift;
  logic tick;
  logic timer_clr;

  assign in_shift = (state_q == SHIFT);

  // The timer idles at 0 outside SHIFT, so a new frame always starts a fresh
  // bit period; an abort also rewinds it so the next frame is aligned.
  assign timer_clr = !in_shift || abort_i;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (in_shift),
    .clr  (timer_clr),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    strb_o    = 1'b0;
    done_o    = 1'b0;

    case (state_q)
      IDLE: begin
        // ready_o is implied by being in IDLE.
        if (valid_i) begin
          shreg_d   = data_i;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (abort_i) begin
          // Abort masks the strobe in the same cycle, so the receiver never
          // shifts on an abandoned bit, and it overrides a coincident last bit.
          state_d   = IDLE;
          shreg_d   = '0;
          bit_cnt_d = '0;
        end else if (tick) begin
          strb_o = 1'b1;
          // Move the next bit toward the output end; the vacated end fills with 0.
          if (MSB_FIRST != 0) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
          end
          if (bit_cnt_q == LAST_BIT) begin
            done_o    = 1'b1;
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign busy_o  = in_shift;
  assign ser_o   = in_shift ? ((MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0])
                            : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_tx.sv
// Purpose : directed self-checking bench for piso_tx (MSB-first CPB=4 and LSB-first CPB=1 instances).
// Latency : n/a (testbench).
// Backpressure : n/a (testbench).
module tb_piso_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, abort_a, abort_b;
  logic       ready_a, ser_a, strb_a, busy_a, done_a;
  logic       ready_b, ser_b, strb_b, busy_b, done_b;

  piso_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .data_i(data_a), .valid_i(valid_a), .ready_o(ready_a),
    .abort_i(abort_a), .ser_o(ser_a), .strb_o(strb_a), .busy_o(busy_a), .done_o(done_a)
  );

  piso_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .data_i(data_b), .valid_i(valid_b), .ready_o(ready_b),
    .abort_i(abort_b), .ser_o(ser_b), .strb_o(strb_b), .busy_o(busy_b), .done_o(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver model: a left-shifting register fed by ser_a/strb_a, plus pulse counters.
  // Sampled mid-cycle, after the bench has driven and the DUT has settled.
  logic [7:0] rx_p = 8'h00;
  int strb_cnt_a = 0;
  int done_cnt_a = 0;
  always @(negedge clk) begin
    #3;
    if (strb_a) begin
      rx_p = {rx_p[6:0], ser_a};
      strb_cnt_a++;
    end
    if (done_a) done_cnt_a++;
  end

  // Advance to the middle of the next cycle; all drives and checks happen here.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Handshake one word into instance A. Returns in cycle T+1 (first bit on the line).
  task automatic hs_a(input logic [7:0] d, input bit hold);
    int guard;
    guard = 0;
    step();
    data_a  = d;
    valid_a = 1'b1;
    while (!ready_a && guard < 60) begin
      step();
      guard++;
    end
    check("hs_ready_a", ready_a, 1);
    step();
    if (!hold) valid_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int guard;
    guard = 0;
    while (!ready_a && guard < 60) begin
      step();
      guard++;
    end
    check("idle_timeout_a", ready_a, 1);
  endtask

  // Cycle-by-cycle frame check for A starting in cycle T+1, ending in cycle T+33.
  task automatic frame_a(input logic [7:0] d);
    logic [7:0] dv;
    dv = d;
    for (int c = 1; c <= 32; c++) begin
      if (c > 1) step();
      check($sformatf("a_ser_c%0d", c), ser_a, dv[7 - ((c - 1) / 4)]);
      check($sformatf("a_strb_c%0d", c), strb_a, (c % 4) == 0);
      check($sformatf("a_done_c%0d", c), done_a, c == 32);
      check($sformatf("a_busy_c%0d", c), busy_a, 1);
    end
    step();
    check("a_ready_after", ready_a, 1);
    check("a_busy_after", busy_a, 0);
    check("a_ser_after", ser_a, 0);
  endtask

  // Frame on instance B (CPB=1, LSB first); abort held through the handshake.
  task automatic frame_b(input logic [7:0] d);
    logic [7:0] dv;
    dv = d;
    step();
    data_b  = d;
    valid_b = 1'b1;
    abort_b = 1'b1;
    check("b_ready_hs", ready_b, 1);
    step();
    valid_b = 1'b0;
    abort_b = 1'b0;
    #1;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) step();
      check($sformatf("b_ser_c%0d", c), ser_b, dv[c - 1]);
      check($sformatf("b_strb_c%0d", c), strb_b, 1);
      check($sformatf("b_done_c%0d", c), done_b, c == 8);
    end
    step();
    check("b_ready_after", ready_b, 1);
    check("b_strb_after", strb_b, 0);
  endtask

  int s0, d0;

  initial begin
    rst = 1'b1;
    data_a = 8'h00; valid_a = 1'b0; abort_a = 1'b0;
    data_b = 8'h00; valid_b = 1'b0; abort_b = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_ser", ser_a, 0);
    check("rst_ready", ready_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_strb", strb_a, 0);
    check("rst_done", done_a, 0);
    check("rst_ready_b", ready_b, 1);

    // 0xA5, full cycle-level timing.
    s0 = strb_cnt_a; d0 = done_cnt_a;
    hs_a(8'hA5, 1'b0);
    frame_a(8'hA5);
    check("a5_rx", rx_p, 8'hA5);
    check("a5_strobes", strb_cnt_a - s0, 8);
    check("a5_dones", done_cnt_a - d0, 1);

    // Loopback 0x3C then 0xFF back-to-back.
    s0 = strb_cnt_a;
    hs_a(8'h3C, 1'b1);
    data_a = 8'hFF;
    wait_idle_a();
    check("lb_3c_rx", rx_p, 8'h3C);
    check("lb_3c_strobes", strb_cnt_a - s0, 8);
    step();
    valid_a = 1'b0;
    check("lb_ff_started", busy_a, 1);
    wait_idle_a();
    check("lb_ff_rx", rx_p, 8'hFF);
    check("lb_total_strobes", strb_cnt_a - s0, 16);

    // valid held with 0x00 during an 0xA5 frame.
    hs_a(8'hA5, 1'b1);
    data_a = 8'h00;
    frame_a(8'hA5);
    check("hold_rx_a5", rx_p, 8'hA5);
    step();
    valid_a = 1'b0;
    check("hold_next_busy", busy_a, 1);
    check("hold_next_ser", ser_a, 0);
    wait_idle_a();
    check("hold_rx_00", rx_p, 8'h00);

    // Abort at T+10.
    d0 = done_cnt_a;
    hs_a(8'hA5, 1'b0);
    repeat (9) step();
    abort_a = 1'b1;
    #1;
    check("abort_strb", strb_a, 0);
    step();
    abort_a = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_ready", ready_a, 1);
    check("abort_ser", ser_a, 0);
    check("abort_done", done_a, 0);
    repeat (4) step();
    check("abort_no_done", done_cnt_a - d0, 0);
    hs_a(8'h81, 1'b0);
    wait_idle_a();
    step();
    check("abort_81_rx", rx_p, 8'h81);
    check("abort_81_done", done_cnt_a - d0, 1);

    // Abort coincident with the final strobe.
    s0 = strb_cnt_a; d0 = done_cnt_a;
    hs_a(8'h5A, 1'b0);
    repeat (31) step();
    check("lastab_strb_pre", strb_a, 1);
    abort_a = 1'b1;
    #1;
    check("lastab_strb", strb_a, 0);
    check("lastab_done", done_a, 0);
    step();
    abort_a = 1'b0;
    check("lastab_ready", ready_a, 1);
    check("lastab_dones", done_cnt_a - d0, 0);
    check("lastab_strobes", strb_cnt_a - s0, 7);

    // Reset at T+20, held one more cycle together with valid.
    hs_a(8'hA5, 1'b0);
    repeat (19) step();
    rst = 1'b1;
    valid_a = 1'b1;
    data_a = 8'hFF;
    step();
    check("mrst_ser", ser_a, 0);
    check("mrst_busy", busy_a, 0);
    check("mrst_ready", ready_a, 1);
    check("mrst_strb", strb_a, 0);
    check("mrst_done", done_a, 0);
    step();
    check("mrst_beats_valid", busy_a, 0);
    rst = 1'b0;
    valid_a = 1'b0;
    s0 = strb_cnt_a; d0 = done_cnt_a;
    repeat (40) step();
    check("mrst_no_strobes", strb_cnt_a - s0, 0);
    check("mrst_no_done", done_cnt_a - d0, 0);

    // CPB=1, LSB first.
    frame_b(8'h01);
    frame_b(8'hB4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
